fetch_stage: RTL and testbench

IF stage of the 5-stage MIPS pipeline. It holds the PC, selects the next PC from PC+4 or the branch target resolved in MEM (PCSrc/branch_addr), reads a word-addressed instruction memory, and loads the IF/ID latch. It supports hazard-unit stall, branch flush, and a preload port for the instruction memory. It also keeps a retired-fetch counter.

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC select, word-addressed
// instruction memory with a preload port, IF/ID latch and a saturating fetch counter.
module fetch_stage #(
    parameter int          IMEM_DEPTH = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc,
    input  logic [31:0] branch_addr,
    input  logic        stall,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] pc_out,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_npc,
    output logic        IF_ID_valid,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic [31:0] fetchCount_q, fetchCount_d;

    logic [31:0] pcPlus4;
    logic [31:0] fetchWord;

    // Address bits outside the word index are deliberately ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{imem_waddr[31:AW+2], imem_waddr[1:0], branch_addr[1:0]};

    assign pcPlus4   = pc_q + 32'd4;
    assign fetchWord = imem[pc_q[AW+1:2]];

    // Memory is not reset; a same-cycle write is seen by the fetch only on the next cycle.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr[AW+1:2]] <= imem_wdata;
        end
    end

    // Redirect beats stall so a taken branch is never lost.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        valid_d      = valid_q;
        fetchCount_d = fetchCount_q;
        if (PCSrc) begin
            pc_d    = {branch_addr[31:2], 2'b00};
            instr_d = 32'h0000_0000;
            npc_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pcPlus4;
            instr_d = fetchWord;
            npc_d   = pcPlus4;
            valid_d = 1'b1;
            if (fetchCount_q != 32'hFFFF_FFFF) begin
                fetchCount_d = fetchCount_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0000_0000;
            npc_q        <= 32'h0000_0000;
            valid_q      <= 1'b0;
            fetchCount_q <= 32'h0000_0000;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
            valid_q      <= valid_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign pc_out      = pc_q;
    assign IF_ID_instr = instr_q;
    assign IF_ID_npc   = npc_q;
    assign IF_ID_valid = valid_q;
    assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written reset
// sequences, then randomized traffic against a rule-level reference model.
module tb_fetch_stage;

    localparam int DEPTH = 128;

    logic        clk;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] branch_addr;
    logic        stall;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc_out;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        IF_ID_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PCSrc(PCSrc),
        .branch_addr(branch_addr),
        .stall(stall),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .pc_out(pc_out),
        .IF_ID_instr(IF_ID_instr),
        .IF_ID_npc(IF_ID_npc),
        .IF_ID_valid(IF_ID_valid),
        .fetch_count(fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pcsrc;
        logic        stl;
        logic [31:0] baddr;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expNpc;
        logic        expValid;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs [$];

    // Reference model: architectural state described by the fetch rules.
    logic [31:0] modelMem [DEPTH];
    logic [31:0] mPc, mInstr, mNpc, mCount;
    logic        mValid;

    function automatic int wordIdx(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic vec_t mkVec(input logic pcsrc, input logic stl, input logic [31:0] baddr,
                                   input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                                   input logic [31:0] ePc, input logic [31:0] eInstr,
                                   input logic [31:0] eNpc, input logic eValid, input logic [31:0] eCount);
        vec_t v;
        v.pcsrc = pcsrc; v.stl = stl; v.baddr = baddr;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.expPc = ePc; v.expInstr = eInstr; v.expNpc = eNpc;
        v.expValid = eValid; v.expCount = eCount;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] ePc, input logic [31:0] eInstr,
                            input logic [31:0] eNpc, input logic eValid, input logic [31:0] eCount);
        checkOutput({tag, ".pc"}, pc_out, ePc);
        checkOutput({tag, ".instr"}, IF_ID_instr, eInstr);
        checkOutput({tag, ".npc"}, IF_ID_npc, eNpc);
        checkOutput({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, eValid});
        checkOutput({tag, ".count"}, fetch_count, eCount);
    endtask

    task automatic applyStimulus(input logic pcsrc, input logic stl, input logic [31:0] baddr,
                                 input logic we, input logic [31:0] waddr, input logic [31:0] wdata);
        PCSrc = pcsrc; stall = stl; branch_addr = baddr;
        imem_we = we; imem_waddr = waddr; imem_wdata = wdata;
        @(posedge clk);
        #1;
        PCSrc = 1'b0; stall = 1'b0; imem_we = 1'b0;
    endtask

    // Advances the model by one edge using the inputs that were presented.
    task automatic modelStep(input logic pcsrc, input logic stl, input logic [31:0] baddr,
                             input logic we, input logic [31:0] waddr, input logic [31:0] wdata);
        logic [31:0] oldWord;
        oldWord = modelMem[wordIdx(mPc)];
        if (pcsrc) begin
            mPc = baddr & 32'hFFFF_FFFC;
            mInstr = 32'd0; mNpc = 32'd0; mValid = 1'b0;
        end else if (!stl) begin
            mInstr = oldWord;
            mNpc = mPc + 32'd4;
            mPc = mPc + 32'd4;
            mValid = 1'b1;
            if (mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
        end
        if (we) modelMem[wordIdx(waddr)] = wdata;
    endtask

    initial begin
        rst_n = 1'b1; PCSrc = 1'b0; stall = 1'b0; branch_addr = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        #2 rst_n = 1'b0;
        #1;
        checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            modelMem[i] = 32'hA000_0000 + 32'(i);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), modelMem[i]);
        end
        checkAll("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;

        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h4, 32'hA000_0000, 32'h4, 1, 1));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h8, 32'hA000_0001, 32'h8, 1, 2));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'hC, 32'hA000_0002, 32'hC, 1, 3));
        vecs.push_back(mkVec(0, 1, 32'h0, 0, 0, 0, 32'hC, 32'hA000_0002, 32'hC, 1, 3));
        vecs.push_back(mkVec(0, 1, 32'h0, 0, 0, 0, 32'hC, 32'hA000_0002, 32'hC, 1, 3));
        vecs.push_back(mkVec(0, 1, 32'h0, 0, 0, 0, 32'hC, 32'hA000_0002, 32'hC, 1, 3));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h10, 32'hA000_0003, 32'h10, 1, 4));
        vecs.push_back(mkVec(1, 0, 32'h40, 0, 0, 0, 32'h40, 32'h0, 32'h0, 0, 4));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h44, 32'hA000_0010, 32'h44, 1, 5));
        vecs.push_back(mkVec(1, 1, 32'h23, 0, 0, 0, 32'h20, 32'h0, 32'h0, 0, 5));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h24, 32'hA000_0008, 32'h24, 1, 6));
        vecs.push_back(mkVec(1, 0, 32'h204, 0, 0, 0, 32'h204, 32'h0, 32'h0, 0, 6));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h208, 32'hA000_0001, 32'h208, 1, 7));
        vecs.push_back(mkVec(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 7));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'hA000_007F, 32'h0, 1, 8));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h4, 32'hA000_0000, 32'h4, 1, 9));
        vecs.push_back(mkVec(0, 0, 32'h0, 1, 32'h4, 32'hDEAD_BEEF, 32'h8, 32'hA000_0001, 32'h8, 1, 10));
        vecs.push_back(mkVec(1, 0, 32'h4, 0, 0, 0, 32'h4, 32'h0, 32'h0, 0, 10));
        vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 0, 32'h8, 32'hDEAD_BEEF, 32'h8, 1, 11));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pcsrc, vecs[i].stl, vecs[i].baddr,
                          vecs[i].we, vecs[i].waddr, vecs[i].wdata);
            if (vecs[i].we) modelMem[wordIdx(vecs[i].waddr)] = vecs[i].wdata;
            checkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expInstr,
                     vecs[i].expNpc, vecs[i].expValid, vecs[i].expCount);
        end

        // Asynchronous reset between edges, with a redirect pending that must be discarded.
        PCSrc = 1'b1; branch_addr = 32'h80;
        #3 rst_n = 1'b0;
        #1;
        checkAll("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        PCSrc = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        checkAll("refetch", 32'h4, modelMem[0], 32'h4, 1'b1, 32'h1);

        mPc = 32'h4; mInstr = modelMem[0]; mNpc = 32'h4; mValid = 1'b1; mCount = 32'h1;
        for (int n = 0; n < 400; n++) begin
            logic        rPcsrc, rStall, rWe;
            logic [31:0] rBaddr, rWaddr, rWdata;
            rPcsrc = ($urandom_range(0, 7) == 0);
            rStall = ($urandom_range(0, 3) == 0);
            rBaddr = $urandom;
            rWe    = ($urandom_range(0, 5) == 0);
            rWaddr = (rWe && $urandom_range(0, 1) == 1) ? mPc : $urandom;
            rWdata = $urandom;
            applyStimulus(rPcsrc, rStall, rBaddr, rWe, rWaddr, rWdata);
            modelStep(rPcsrc, rStall, rBaddr, rWe, rWaddr, rWdata);
            checkAll($sformatf("rand%0d", n), mPc, mInstr, mNpc, mValid, mCount);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
